// File: rtl/uart_rx_os16.sv
// UART receiver fed by a one-cycle 16x-oversample enable (rx_tick); delivers words with a valid/ack handshake.
// Optional parity bit after the data bits: define UART_RX_PARITY_EN (sense selected by PARITY_ODD).
module uart_rx_os16 #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk_50,
    input  logic                 RESET,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = S_PARITY;
`else
    localparam state_e AFTER_DATA = S_STOP;
`endif

    state_e               state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync_q, rxs_q;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 stop_sample;
    logic                 deliver;
    logic                 parity_ok;

    // NOTE: rxd is asynchronous to clk_50; two flops resolve metastability before any decision sees it.
    always_ff @(posedge clk_50 or posedge RESET) begin
        if (RESET) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= rxd;
            rxs_q  <= sync_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        if (rx_tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            case (state_q)
                S_IDLE: begin
                    tick_cnt_d = '0;
                    if (!rxs_q) state_d = S_START;
                end
                S_START: begin
                    // Mid start bit: a line that is high again was a glitch.
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxs_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) state_d = AFTER_DATA;
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        state_d    = rxs_q ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    // A held-low line must go high before a new start bit is accepted.
                    tick_cnt_d = '0;
                    if (rxs_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;
    logic parity_err_q;

    always_ff @(posedge clk_50 or posedge RESET) begin
        if (RESET) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (rx_tick && state_q == S_PARITY && tick_cnt_q == 4'd15) par_bit_q <= rxs_q;
            parity_err_q <= stop_sample && rxs_q && !parity_ok;
        end
    end

    assign parity_ok  = (par_bit_q == ((^shift_q) ^ PARITY_ODD));
    assign parity_err = parity_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign parity_ok         = 1'b1;
    assign parity_err        = 1'b0;
`endif

    always_comb begin
        stop_sample = rx_tick && (state_q == S_STOP) && (tick_cnt_q == 4'd15);
        deliver     = stop_sample && rxs_q && parity_ok;
        frame_err_d = stop_sample && !rxs_q;
        busy        = (state_q != S_IDLE);

        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (data_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        // A delivery on top of an unacknowledged word replaces it and marks the loss.
        if (deliver) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !data_ack) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50 or posedge RESET) begin
        if (RESET) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: frame-level timing model with a per-cycle output compare.
`timescale 1ns/1ps
module tb_uart_rx_os16;

    localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB  = 1;
    localparam int LAT = 171;
`else
    localparam int PB  = 0;
    localparam int LAT = 155;
`endif
    localparam int FRAME_BITS = DATA_BITS + 2 + PB;

    logic                 clk_50   = 1'b0;
    logic                 RESET    = 1'b1;
    logic                 rx_tick  = 1'b1;
    logic                 rxd      = 1'b1;
    logic                 data_ack = 1'b0;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid, frame_err, parity_err, overrun, busy;

    uart_rx_os16 #(.DATA_BITS(DATA_BITS), .PARITY_ODD(1'b0)) dut (
        .clk_50    (clk_50),
        .RESET     (RESET),
        .rx_tick   (rx_tick),
        .rxd       (rxd),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ack  (data_ack),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk_50 = ~clk_50;

    typedef enum {EV_BUSY_ON, EV_BUSY_OFF, EV_DELIVER, EV_FERR, EV_PERR} ev_kind_e;
    typedef struct {
        int       cyc;
        ev_kind_e kind;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         model_on = 1'b0;
    bit         rand_ack = 1'b0;
    int         tick_div = 1;
    bit         exp_valid, exp_ovr, exp_fe, exp_pe, exp_busy;
    logic [7:0] exp_data;
    bit         dv_prev = 1'b0;
    int         rise_cyc = 0;
    int         fe_count = 0;
    int         pe_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.data = d;
        evq.push_back(e);
    endtask

    // Reference model: applies the handshake rules and the frame events scheduled by the driver.
    always @(posedge clk_50) begin
        bit vprev;
        cyc = cyc + 1;
        if (RESET) begin
            exp_valid = 0; exp_ovr = 0; exp_fe = 0; exp_pe = 0; exp_busy = 0;
            exp_data  = '0;
            evq.delete();
        end else begin
            vprev  = exp_valid;
            exp_fe = 0;
            exp_pe = 0;
            if (data_ack && vprev) begin
                exp_valid = 0;
                exp_ovr   = 0;
            end
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].cyc == cyc) begin
                    case (evq[i].kind)
                        EV_BUSY_ON:  exp_busy = 1;
                        EV_BUSY_OFF: exp_busy = 0;
                        EV_FERR:     exp_fe = 1;
                        EV_PERR:     exp_pe = 1;
                        EV_DELIVER: begin
                            exp_data  = evq[i].data;
                            if (vprev && !data_ack) exp_ovr = 1;
                            exp_valid = 1;
                        end
                        default: ;
                    endcase
                    evq.delete(i);
                end
            end
        end
    end

    always @(negedge clk_50) begin
        if (model_on && !RESET) begin
            check("data_valid", data_valid, exp_valid);
            check("data_out", data_out, exp_data);
            check("overrun", overrun, exp_ovr);
            check("frame_err", frame_err, exp_fe);
            check("parity_err", parity_err, exp_pe);
            check("busy", busy, exp_busy);
        end
        if (data_valid && !dv_prev) rise_cyc = cyc;
        dv_prev = data_valid;
        if (frame_err) fe_count++;
        if (parity_err) pe_count++;
    end

    always @(posedge clk_50) begin
        #1;
        if (rand_ack) data_ack = ($urandom_range(0, 5) == 0);
        rx_tick = (tick_div <= 1) ? 1'b1 : ((cyc % tick_div) == 0);
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    // Drives one frame; with track set, schedules what the receiver must do and when.
    // Bit j is sampled 16*j + 11 edges after the start bit is driven (2 sync + detect + 8 ticks).
    task automatic send_frame(input logic [7:0] d, input bit stop_val, input bit bad_par,
                              input int bl, input bit track);
        logic [FRAME_BITS-1:0] bits;
        int k, e;
        k = cyc;
        e = k + 11 + 16 * (FRAME_BITS - 1);
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) bits[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
        bits[DATA_BITS + 1] = (^d) ^ 1'b0 ^ bad_par;
`endif
        bits[FRAME_BITS - 1] = stop_val;
        if (track) begin
            push_ev(k + 3, EV_BUSY_ON, 8'h00);
            if (!stop_val) begin
                push_ev(e, EV_FERR, 8'h00);
            end else if (bad_par && PB == 1) begin
                push_ev(e, EV_PERR, 8'h00);
                push_ev(e, EV_BUSY_OFF, 8'h00);
            end else begin
                push_ev(e, EV_DELIVER, d);
                push_ev(e, EV_BUSY_OFF, 8'h00);
            end
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            rxd = bits[i];
            hold(bl);
        end
    endtask

    task automatic release_break(input int low_cycles);
        hold(low_cycles);
        rxd = 1'b1;
        push_ev(cyc + 3, EV_BUSY_OFF, 8'h00);
        hold(4);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!data_valid && n < budget) begin
            hold(1);
            n++;
        end
        check(name, data_valid, 1'b1);
    endtask

    task automatic ack_once();
        data_ack = 1'b1;
        hold(1);
        data_ack = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, fe_base, pe_base;
        logic [7:0] d;

        hold(5);
        RESET = 1'b0;
        check("reset data_out", data_out, 8'h00);
        check("reset data_valid", data_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset overrun", overrun, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        hold(2);
        model_on = 1'b1;

        // 0xA5 with continuous ticks: exact latency from start edge.
        k = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, 16, 1'b1);
        check("A5 latency", rise_cyc - k, LAT);
        check("A5 data", data_out, 8'hA5);
        check("A5 no frame_err", fe_count, 0);
        ack_once();
        hold(3);

        // 4-cycle glitch, then a real frame.
        k = cyc;
        push_ev(k + 3, EV_BUSY_ON, 8'h00);
        push_ev(k + 11, EV_BUSY_OFF, 8'h00);
        rxd = 1'b0;
        hold(4);
        rxd = 1'b1;
        hold(20);
        check("glitch no valid", data_valid, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 16, 1'b1);
        check("post-glitch data", data_out, 8'h3C);
        ack_once();
        hold(3);

        // Stop bit low, line held low, then recovery.
        fe_base = fe_count;
        send_frame(8'h55, 1'b0, 1'b0, 16, 1'b1);
        release_break(100);
        check("frame_err pulses", fe_count - fe_base, 1);
        check("break no valid", data_valid, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, 16, 1'b1);
        check("post-break data", data_out, 8'h12);
        ack_once();
        hold(3);

        // Overrun: two words without ack.
        send_frame(8'h3C, 1'b1, 1'b0, 16, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b0, 16, 1'b1);
        check("overrun data", data_out, 8'hC3);
        check("overrun flag", overrun, 1'b1);
        ack_once();
        check("ack clears valid", data_valid, 1'b0);
        check("ack clears overrun", overrun, 1'b0);
        hold(3);

        // Reset during bit 3 of 0xFF while an unacked word is held.
        send_frame(8'h5A, 1'b1, 1'b0, 16, 1'b1);
        model_on = 1'b0;
        rxd = 1'b0;
        hold(16);
        rxd = 1'b1;
        hold(48 + 8);
        #3;
        RESET = 1'b1;
        #1;
        check("midreset data_out", data_out, 8'h00);
        check("midreset data_valid", data_valid, 1'b0);
        check("midreset busy", busy, 1'b0);
        check("midreset overrun", overrun, 1'b0);
        hold(3);
        RESET = 1'b0;
        hold(3);
        model_on = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, 16, 1'b1);
        check("post-reset data", data_out, 8'h81);
        ack_once();
        hold(3);

`ifdef UART_RX_PARITY_EN
        pe_base = pe_count;
        send_frame(8'h07, 1'b1, 1'b0, 16, 1'b1);
        check("parity good data", data_out, 8'h07);
        check("parity good valid", data_valid, 1'b1);
        ack_once();
        hold(3);
        send_frame(8'h07, 1'b1, 1'b1, 16, 1'b1);
        check("parity bad pulses", pe_count - pe_base, 1);
        check("parity bad no valid", data_valid, 1'b0);
        hold(3);
`else
        pe_base = pe_count;
`endif

        // Randomised frames, gaps, framing errors and ack timing.
        rand_ack = 1'b1;
        for (int n = 0; n < 40; n++) begin
            bit err, bad;
            d   = 8'($urandom);
            err = ($urandom_range(0, 9) == 0);
            bad = ($urandom_range(0, 7) == 0);
            hold($urandom_range(0, 20));
            send_frame(d, !err, bad, 16, 1'b1);
            if (err) release_break($urandom_range(1, 40));
        end
        rand_ack = 1'b0;
        data_ack = 1'b0;
        hold(2);
        ack_once();
        hold(20);
`ifndef UART_RX_PARITY_EN
        check("no parity_err in default build", pe_count - pe_base, 0);
`endif

        // Ticks every 4 clocks: state must freeze between ticks (64 clk per bit).
        model_on = 1'b0;
        tick_div = 4;
        hold(2);
        send_frame(8'h96, 1'b1, 1'b0, 64, 1'b0);
        wait_valid("gated valid", 200);
        check("gated data", data_out, 8'h96);
        ack_once();
        tick_div = 1;
        hold(4);
        exp_valid = 0; exp_ovr = 0; exp_fe = 0; exp_pe = 0; exp_busy = 0;
        exp_data  = 8'h96;
        evq.delete();
        model_on = 1'b1;
        send_frame(8'hE7, 1'b1, 1'b0, 16, 1'b1);
        check("final data", data_out, 8'hE7);
        ack_once();
        hold(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
